// File: rtl/key_expansion.sv
// AES-128 key-schedule sequencer: emits round keys 0..NUM_ROUNDS, one per clock,
// using an external combinational sub_word fed with RotWord of the last word.
module key_expansion #(
  parameter int regSize    = 32,
  parameter int NUM_ROUNDS = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*regSize-1:0]   key_in,
  output logic [regSize-1:0]     sub_in,
  input  logic [regSize-1:0]     sub_out,
  output logic                   busy,
  output logic                   rk_valid,
  output logic [3:0]             rk_index,
  output logic [4*regSize-1:0]   rk_out,
  output logic                   done
);

  typedef enum logic {IDLE = 1'b0, EXPAND = 1'b1} state_t;

  state_t             state_reg, state_next;
  logic [regSize-1:0] w_reg  [4];
  logic [regSize-1:0] w_next [4];
  logic [regSize-1:0] step_w [4];
  logic [3:0]         idx_reg, idx_next;
  logic [7:0]         rcon_byte;
  logic [regSize-1:0] t_word;
  logic               last_round;

  // Rcon for the round being produced, i.e. Rcon(idx+1).
  always_comb begin
    rcon_byte = 8'h00;
    case (idx_reg)
      4'd0: rcon_byte = 8'h01;
      4'd1: rcon_byte = 8'h02;
      4'd2: rcon_byte = 8'h04;
      4'd3: rcon_byte = 8'h08;
      4'd4: rcon_byte = 8'h10;
      4'd5: rcon_byte = 8'h20;
      4'd6: rcon_byte = 8'h40;
      4'd7: rcon_byte = 8'h80;
      4'd8: rcon_byte = 8'h1b;
      4'd9: rcon_byte = 8'h36;
      default: rcon_byte = 8'h00;
    endcase
  end

  assign sub_in = {w_reg[3][regSize-9:0], w_reg[3][regSize-1:regSize-8]};
  assign t_word = sub_out ^ {rcon_byte, {(regSize-8){1'b0}}};

  // Ripple XOR chain: each new word depends on the freshly computed previous one.
  always_comb begin
    step_w[0] = w_reg[0] ^ t_word;
    for (int i = 1; i < 4; i++) begin
      step_w[i] = w_reg[i] ^ step_w[i-1];
    end
  end

  assign last_round = (idx_reg == 4'(NUM_ROUNDS));

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    for (int i = 0; i < 4; i++) begin
      w_next[i] = w_reg[i];
    end
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = EXPAND;
          idx_next   = 4'd0;
          for (int i = 0; i < 4; i++) begin
            w_next[i] = key_in[(4-i)*regSize-1 -: regSize];
          end
        end
      end
      EXPAND: begin
        if (!last_round) begin
          idx_next = idx_reg + 4'd1;
          for (int i = 0; i < 4; i++) begin
            w_next[i] = step_w[i];
          end
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        w_reg[i] <= '0;
      end
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      for (int i = 0; i < 4; i++) begin
        w_reg[i] <= w_next[i];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rk_pack
      assign rk_out[(4-gi)*regSize-1 -: regSize] = w_reg[gi];
    end
  endgenerate

  assign rk_index = idx_reg;
  assign rk_valid = (state_reg == EXPAND);
  assign busy     = (state_reg == EXPAND);
  assign done     = (state_reg == EXPAND) && last_round;

endmodule

// File: tb/tb_key_expansion.sv
// Self-checking bench for key_expansion: attaches a real AES S-box as sub_word and
// compares every emitted round key against a word-array key-schedule model.
module tb_key_expansion;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic [31:0]  sub_in;
  logic [31:0]  sub_out;
  logic         busy;
  logic         rk_valid;
  logic [3:0]   rk_index;
  logic [127:0] rk_out;
  logic         done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   sbox [256];
  logic [127:0] exp_rk [11];
  logic [127:0] seen_rk1, seen_rk10;
  logic [31:0]  seen_sub0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  key_expansion #(.regSize(32), .NUM_ROUNDS(10)) dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in),
    .sub_in(sub_in), .sub_out(sub_out), .busy(busy), .rk_valid(rk_valid),
    .rk_index(rk_index), .rk_out(rk_out), .done(done)
  );

  always #5 clk = ~clk;

  always_comb begin
    sub_out = {sbox[sub_in[31:24]], sbox[sub_in[23:16]], sbox[sub_in[15:8]], sbox[sub_in[7:0]]};
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int x = 1; x < 256; x++) begin
        if (gf_mul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
      end
      sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_rot(input logic [31:0] v);
    logic [31:0] r = {v[23:0], v[31:24]};
    return {sbox[r[31:24]], sbox[r[23:16]], sbox[r[15:8]], sbox[r[7:0]]};
  endfunction

  // Textbook FIPS-197 schedule over a flat array of 44 words.
  task automatic model(input logic [127:0] key);
    logic [31:0] w [44];
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      logic [31:0] t = w[i-1];
      if (i % 4 == 0) begin
        t  = sub_rot(t) ^ {rc, 24'h0};
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},     128'(busy),     128'd0);
    check({tag, "_rk_valid"}, 128'(rk_valid), 128'd0);
    check({tag, "_done"},     128'(done),     128'd0);
  endtask

  // One complete run; key_in is scrambled after acceptance to show it is not resampled.
  task automatic do_run(input logic [127:0] key, input string tag);
    model(key);
    key_in = key;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 11; i++) begin
      check($sformatf("%s_valid%0d", tag, i), 128'(rk_valid), 128'd1);
      check($sformatf("%s_busy%0d", tag, i),  128'(busy),     128'd1);
      check($sformatf("%s_idx%0d", tag, i),   128'(rk_index), 128'(i));
      check($sformatf("%s_rk%0d", tag, i),    rk_out,         exp_rk[i]);
      check($sformatf("%s_done%0d", tag, i),  128'(done),     128'(i == 10));
      if (i == 0) begin
        seen_sub0 = sub_in;
        check({tag, "_sub_in0"}, 128'(sub_in), 128'({key[23:0], key[31:24]}));
      end
      if (i == 1)  seen_rk1  = rk_out;
      if (i == 10) seen_rk10 = rk_out;
      tick();
    end
    check_idle({tag, "_after"});
    $display("run %s key=%h rk10=%h", tag, key, seen_rk10);
  endtask

  initial begin
    build_sbox();
    rst = 1'b1; start = 1'b0; key_in = '0;
    repeat (3) tick();
    check("reset_rk_out",   rk_out,          128'd0);
    check("reset_rk_index", 128'(rk_index),  128'd0);
    check("reset_sub_in",   128'(sub_in),    128'd0);
    check_idle("reset");
    rst = 1'b0;
    tick();

    do_run(FIPS_KEY, "fips");
    check("fips_sub_in_lit", 128'(seen_sub0), 128'(32'hcf4f3c09));
    check("fips_rk1_lit",  seen_rk1,  128'ha0fafe1788542cb123a339392a6c7605);
    check("fips_rk10_lit", seen_rk10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    do_run(128'd0, "zero");
    check("zero_rk1_lit",  seen_rk1,  128'h62636363626363636263636362636363);
    check("zero_rk10_lit", seen_rk10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    for (int k = 0; k < 4; k++) begin
      do_run({$urandom, $urandom, $urandom, $urandom}, $sformatf("rand%0d", k));
    end

    // start held high: one idle cycle, then a rerun with index 0 at cycle 13.
    model(FIPS_KEY);
    key_in = FIPS_KEY;
    start  = 1'b1;
    tick();
    for (int i = 0; i < 11; i++) begin
      check($sformatf("hold_idx%0d", i), 128'(rk_index), 128'(i));
      check($sformatf("hold_valid%0d", i), 128'(rk_valid), 128'd1);
      tick();
    end
    check_idle("hold_gap");
    tick();
    check("hold_rerun_valid", 128'(rk_valid), 128'd1);
    check("hold_rerun_idx",   128'(rk_index), 128'd0);
    check("hold_rerun_rk",    rk_out,         exp_rk[0]);
    start = 1'b0;
    for (int i = 1; i < 11; i++) tick();
    check("hold_rerun_rk10",  rk_out,         exp_rk[10]);
    check("hold_rerun_done",  128'(done),     128'd1);
    tick();
    check_idle("hold_end");
    $display("run start_held done");

    // Reset while rk_index is 4 aborts the run.
    key_in = FIPS_KEY;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    repeat (4) tick();
    check("abort_idx4", 128'(rk_index), 128'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_rk_out",   rk_out,         128'd0);
    check("abort_rk_index", 128'(rk_index), 128'd0);
    check("abort_sub_in",   128'(sub_in),   128'd0);
    check_idle("abort");
    begin
      int stray = 0;
      for (int i = 0; i < 15; i++) begin
        if (rk_valid || done || busy) stray++;
        tick();
      end
      check("abort_no_activity", 128'(stray), 128'd0);
    end
    $display("run abort_at_idx4 done");
    do_run(FIPS_KEY, "post_abort");
    check("post_abort_rk10_lit", seen_rk10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // rst and start together: reset wins.
    rst = 1'b1; start = 1'b1; key_in = FIPS_KEY;
    tick();
    rst = 1'b0; start = 1'b0;
    check_idle("rst_start_c1");
    tick();
    check_idle("rst_start_c2");
    $display("run rst_and_start done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
